mux8way16_arbiter: RTL and testbench

//   Round-robin arbiter that shares one 16-bit Mux8Way16 datapath among eight requesters.

---
 rtl/mux8way16_arbiter.sv | 121 ++++++++++++
 tb/tb_mux8way16_arbiter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/mux8way16_arbiter.sv
// Round-robin arbiter sharing one 16-bit Mux8Way16 datapath among eight requesters.
// Grant, valid and sel are registered; out is the shared mux output gated by valid.

module mux8way16 (
   input  logic [127:0] data,
   input  logic [2:0]   sel,
   output logic [15:0]  out
);
   always_comb begin
      out = '0;
      case (sel)
         3'd0:    out = data[15:0];
         3'd1:    out = data[31:16];
         3'd2:    out = data[47:32];
         3'd3:    out = data[63:48];
         3'd4:    out = data[79:64];
         3'd5:    out = data[95:80];
         3'd6:    out = data[111:96];
         3'd7:    out = data[127:112];
         default: out = '0;
      endcase
   end
endmodule

module mux8way16_arbiter #(
   parameter int unsigned MAX_HOLD = 8,
   parameter int unsigned HOLD_W   = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [7:0]   req,
   input  logic [127:0] data,
   output logic [7:0]   grant,
   output logic [2:0]   sel,
   output logic         valid,
   output logic [15:0]  out
);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t            state, state_n;
   logic [2:0]        owner, owner_n;
   logic [2:0]        ptr, ptr_n;
   logic [HOLD_W-1:0] count, count_n;
   logic [7:0]        grant_n;
   logic              valid_n;
   logic [15:0]       word_c;

   // First requester at or after start, wrapping modulo 8.
   function automatic logic [2:0] pick(input logic [2:0] start, input logic [7:0] r);
      logic [2:0] idx;
      pick = start;
      for (int i = 7; i >= 0; i--) begin
         idx = start + 3'(i);
         if (r[idx]) pick = idx;
      end
   endfunction

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         owner <= '0;
         ptr   <= '0;
         count <= '0;
         grant <= '0;
         valid <= 1'b0;
      end else begin
         state <= state_n;
         owner <= owner_n;
         ptr   <= ptr_n;
         count <= count_n;
         grant <= grant_n;
         valid <= valid_n;
      end
   end

   always_comb begin
      state_n = state;
      owner_n = owner;
      ptr_n   = ptr;
      count_n = count;
      case (state)
         IDLE: begin
            if (|req) begin
               owner_n = pick(ptr, req);
               count_n = '0;
               state_n = BUSY;
            end
         end
         BUSY: begin
            if (req[owner] && (count < HOLD_LAST)) begin
               count_n = count + HOLD_W'(1);
            end else begin
               // Release; re-arbitrate in the same edge so the bus never bubbles.
               ptr_n = owner + 3'd1;
               if (|req) begin
                  owner_n = pick(owner + 3'd1, req);
                  count_n = '0;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
      valid_n = (state_n == BUSY);
      grant_n = valid_n ? (8'd1 << owner_n) : 8'h00;
   end

   assign sel = owner;

   mux8way16 u_mux (
      .data (data),
      .sel  (sel),
      .out  (word_c)
   );

   assign out = valid ? word_c : 16'h0000;

endmodule

// File: tb/tb_mux8way16_arbiter.sv
// Directed bench for mux8way16_arbiter: reset, latency, hold limit, round-robin order,
// idle return, async reset mid-grant and sole-requester re-grant.

module tb_mux8way16_arbiter;
   logic         clock;
   logic         reset;
   logic [7:0]   req;
   logic [127:0] data;
   logic [7:0]   grant;
   logic [2:0]   sel;
   logic         valid;
   logic [15:0]  out;

   logic [15:0] words [8];
   int          total;
   int          passed;

   mux8way16_arbiter #(.MAX_HOLD(8), .HOLD_W(4)) dut (
      .clock (clock),
      .reset (reset),
      .req   (req),
      .data  (data),
      .grant (grant),
      .sel   (sel),
      .valid (valid),
      .out   (out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic expect_busy(input int o);
      logic [7:0] g;
      g = 8'd1 << o;
      check("grant", 16'(grant), 16'(g));
      check("sel",   16'(sel),   16'(o));
      check("valid", 16'(valid), 16'd1);
      check("out",   out,        words[o]);
   endtask

   task automatic expect_idle(input int last);
      check("idle_grant", 16'(grant), 16'h0000);
      check("idle_sel",   16'(sel),   16'(last));
      check("idle_valid", 16'(valid), 16'd0);
      check("idle_out",   out,        16'h0000);
   endtask

   initial begin
      total  = 0;
      passed = 0;
      for (int i = 0; i < 8; i++) words[i] = 16'hC000 | 16'(i);
      words[3] = 16'h0003;
      for (int i = 0; i < 8; i++) data[16*i +: 16] = words[i];
      req   = 8'h00;
      reset = 1'b1;
      #1;
      expect_idle(0);
      step();
      step();
      reset = 1'b0;

      // Single request from IDLE: one-edge latency, then 8-cycle hold limit.
      req = 8'h08;
      step();
      expect_busy(3);
      for (int k = 1; k < 8; k++) begin
         step();
         expect_busy(3);
      end
      req = 8'h00;
      step();
      expect_idle(3);

      // ptr=4 in IDLE: requester 5 wins over 2, then 2 follows.
      req = 8'h24;
      step();
      expect_busy(5);
      req = 8'h04;
      step();
      expect_busy(2);

      // Owner 6 drops with no other request: IDLE, ptr=7, then 7 wins over 0.
      req = 8'h40;
      step();
      expect_busy(6);
      req = 8'h00;
      step();
      expect_idle(6);
      req = 8'h81;
      step();
      expect_busy(7);

      // Async reset while owner=5 clears outputs before any edge.
      req = 8'h20;
      step();
      expect_busy(5);
      reset = 1'b1;
      #1;
      expect_idle(0);
      step();
      reset = 1'b0;
      step();
      expect_busy(5);

      // Sole requester 1 for 20 cycles: grant never drops.
      req = 8'h02;
      step();
      expect_busy(1);
      for (int k = 1; k <= 20; k++) begin
         step();
         check("sole_grant", 16'(grant), 16'h0002);
      end
      // count is now 4: three more holds, then release to 0 via ptr=2.
      req = 8'h03;
      for (int k = 0; k < 3; k++) begin
         step();
         expect_busy(1);
      end
      step();
      expect_busy(0);

      // All requesting: each owner in turn for exactly 8 cycles, no gaps.
      reset = 1'b1;
      #1;
      expect_idle(0);
      step();
      reset = 1'b0;
      req = 8'hFF;
      for (int k = 0; k <= 64; k++) begin
         step();
         check("rr_valid", 16'(valid), 16'd1);
         check("rr_sel",   16'(sel),   16'((k / 8) % 8));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
